fetch_buffer_super: RTL and testbench

FETCH_BUFFER_SUPER -- requirements
Module: fetch_buffer_super

---
 rtl/fetch_buffer_super.sv | 114 +++++++++++
 tb/tb_fetch_buffer_super.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer_super.sv
// Fetch buffer between the fetch stage and a three-wide decoder.
// Up to five instructions per cycle are written into a circular buffer.
// Decode sees the oldest three entries and consumes up to three per cycle.
// A flush discards everything. Any protocol misuse raises a sticky error flag.
module fetch_buffer_super #(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     fetch_valid_i,
    input  logic [2:0]               fetch_count_i,
    input  logic [31:0]              fetch_pc_i,
    input  logic [159:0]             fetch_inst_i,
    output logic                     buble_o,
    output logic [2:0]               dec_valid_o,
    output logic [95:0]              dec_inst_o,
    output logic [95:0]              dec_pc_o,
    input  logic [1:0]               dec_accept_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] NOP      = 32'h00000013;
    // Stall once fewer than five free slots remain, which means a full group cannot fit.
    localparam logic [AW:0] BUBLE_AT = (AW + 1)'(DEPTH - 4);

    // An unsupported depth or a misaligned reset pc is a build-time mistake.
    if (DEPTH < 8 || (DEPTH & (DEPTH - 1)) != 0 || RESET_PC[1:0] != 2'b00) begin : g_param_check
        $error("fetch_buffer_super: DEPTH must be a power of two >= 8 and RESET_PC word aligned");
    end

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic          err;

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          count_ok;
    logic          enq;
    logic [2:0]    enq_n;
    logic [1:0]    avail;
    logic [1:0]    deq_m;
    logic          err_set;
    logic [AW:0]   count_next;

    // The stall depends only on the registered occupancy. A flush releases it.
    assign buble_o = (count >= BUBLE_AT) && !flush_i;

    // Work out how many entries enter and leave this cycle, and detect protocol errors.
    always_comb begin
        count_ok   = (fetch_count_i >= 3'd1) && (fetch_count_i <= 3'd5);
        enq        = fetch_valid_i && !buble_o && !flush_i && count_ok;
        enq_n      = enq ? fetch_count_i : 3'd0;
        avail      = (count >= (AW + 1)'(3)) ? 2'd3 : count[1:0];
        deq_m      = (dec_accept_i > avail) ? avail : dec_accept_i;
        err_set    = !flush_i &&
                     ((fetch_valid_i && !buble_o && !count_ok) || (dec_accept_i > avail));
        count_next = count + (AW + 1)'(enq_n) - (AW + 1)'(deq_m);
    end

    // Pointer, occupancy and sticky error state. A flush clears the pointers but keeps the error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(deq_m);
            tail  <= tail + AW'(enq_n);
            count <= count_next;
            err   <= err | err_set;
        end
    end

    // Write the accepted group at tail onward, wrapping. Held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && enq) begin
            for (int i = 0; i < 5; i++) begin
                if (3'(i) < enq_n) begin
                    inst_mem[tail + AW'(i)] <= fetch_inst_i[32*i +: 32];
                    pc_mem[tail + AW'(i)]   <= fetch_pc_i + 32'(4 * i);
                end
            end
        end
    end

    // Present the oldest three entries to decode. Empty slots show a NOP at pc 0.
    always_comb begin
        dec_valid_o = 3'b000;
        dec_inst_o  = {3{NOP}};
        dec_pc_o    = '0;
        for (int j = 0; j < 3; j++) begin
            if (count > (AW + 1)'(j)) begin
                dec_valid_o[j]        = 1'b1;
                dec_inst_o[32*j +: 32] = inst_mem[head + AW'(j)];
                dec_pc_o[32*j +: 32]   = pc_mem[head + AW'(j)];
            end
        end
    end

    assign count_o = count;
    assign err_o   = err;

endmodule

// File: tb/tb_fetch_buffer_super.sv
// Self-checking bench for fetch_buffer_super.
// It runs a table of constant vectors, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_buffer_super;

    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush;
    logic         fv;
    logic [2:0]   fc;
    logic [31:0]  fpc;
    logic [159:0] finst;
    logic [1:0]   acc;
    logic         buble;
    logic [2:0]   dvalid;
    logic [95:0]  dinst;
    logic [95:0]  dpc;
    logic [4:0]   count;
    logic         err;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t mq[$];
    logic   merr;

    typedef struct {
        logic        flush;
        logic        fv;
        logic [2:0]  cnt;
        logic [31:0] pc;
        logic [1:0]  acc;
        logic [4:0]  exp_count;
        logic [2:0]  exp_valid;
        logic        exp_buble;
        logic        exp_err;
        logic [31:0] exp_pc0;
    } vector_t;

    vector_t vec[8];

    fetch_buffer_super #(.DEPTH(DEPTH), .RESET_PC(32'h80000000)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush),
        .fetch_valid_i (fv),
        .fetch_count_i (fc),
        .fetch_pc_i    (fpc),
        .fetch_inst_i  (finst),
        .buble_o       (buble),
        .dec_valid_o   (dvalid),
        .dec_inst_o    (dinst),
        .dec_pc_o      (dpc),
        .dec_accept_i  (acc),
        .count_o       (count),
        .err_o         (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Compare one value and keep the pass and total counts.
    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    // Drive one set of inputs. Each instruction word is derived from its pc so it can be traced.
    task automatic applyStimulus(input logic f, input logic v, input logic [2:0] n,
                                 input logic [31:0] pc, input logic [1:0] a);
        flush = f;
        fv    = v;
        fc    = n;
        fpc   = pc;
        acc   = a;
        for (int i = 0; i < 5; i++) finst[32*i +: 32] = (pc + 32'(4 * i)) ^ 32'h5A5A0000;
    endtask

    // Compare all outputs with the expectation built from the model queue.
    task automatic checkOutput(input string tag);
        logic [95:0] ei;
        logic [95:0] ep;
        logic [2:0]  ev;
        int          sz;
        sz = mq.size();
        ei = {3{NOP}};
        ep = '0;
        ev = '0;
        for (int j = 0; j < 3; j++) begin
            if (j < sz) begin
                ev[j]          = 1'b1;
                ei[32*j +: 32] = mq[j].inst;
                ep[32*j +: 32] = mq[j].pc;
            end
        end
        check({tag, ".count"}, 96'(count), 96'(sz));
        check({tag, ".buble"}, 96'(buble), 96'(((DEPTH - sz) < 5) && !flush));
        check({tag, ".valid"}, 96'(dvalid), 96'(ev));
        check({tag, ".inst"},  dinst, ei);
        check({tag, ".pc"},    dpc, ep);
        check({tag, ".err"},   96'(err), 96'(merr));
    endtask

    // Advance the reference model by one clock edge, using the inputs currently driven.
    task automatic modelStep();
        int sz;
        int valid;
        int m;
        bit mb;
        sz    = mq.size();
        valid = (sz < 3) ? sz : 3;
        mb    = ((DEPTH - sz) < 5) && !flush;
        if (flush) begin
            mq.delete();
        end else begin
            if (int'(acc) > valid) merr = 1'b1;
            m = (int'(acc) > valid) ? valid : int'(acc);
            repeat (m) void'(mq.pop_front());
            if (fv && !mb) begin
                if (fc >= 3'd1 && fc <= 3'd5) begin
                    for (int i = 0; i < int'(fc); i++) begin
                        entry_t e;
                        e.inst = finst[32*i +: 32];
                        e.pc   = fpc + 32'(4 * i);
                        mq.push_back(e);
                    end
                end else begin
                    merr = 1'b1;
                end
            end
        end
    endtask

    // Run one model-checked cycle: drive at the falling edge, check, then update the model for the next edge.
    task automatic runCycle(input string tag, input logic f, input logic v, input logic [2:0] n,
                            input logic [31:0] pc, input logic [1:0] a);
        @(negedge clk);
        applyStimulus(f, v, n, pc, a);
        #1;
        checkOutput(tag);
        modelStep();
    endtask

    // Wait until just after the next rising edge.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check the asynchronous clear, then release it.
    task automatic doReset(input string tag);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'd0);
        #2;
        reset = 1'b0;
        #1;
        check({tag, ".count"}, 96'(count), 96'(0));
        check({tag, ".valid"}, 96'(dvalid), 96'(0));
        check({tag, ".buble"}, 96'(buble), 96'(0));
        check({tag, ".err"},   96'(err), 96'(0));
        check({tag, ".inst"},  dinst, {3{NOP}});
        check({tag, ".pc"},    dpc, 96'(0));
        mq.delete();
        merr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'd0);

        // flush fv cnt pc acc -> count valid buble err pc0
        vec[0] = '{1'b0, 1'b1, 3'd5, 32'h80000000, 2'd0, 5'd5,  3'b111, 1'b0, 1'b0, 32'h80000000};
        vec[1] = '{1'b0, 1'b1, 3'd4, 32'h80000014, 2'd3, 5'd6,  3'b111, 1'b0, 1'b0, 32'h8000000C};
        vec[2] = '{1'b0, 1'b1, 3'd5, 32'h80000024, 2'd0, 5'd11, 3'b111, 1'b0, 1'b0, 32'h8000000C};
        vec[3] = '{1'b0, 1'b1, 3'd1, 32'h80000038, 2'd0, 5'd12, 3'b111, 1'b1, 1'b0, 32'h8000000C};
        vec[4] = '{1'b0, 1'b1, 3'd5, 32'h8000003C, 2'd0, 5'd12, 3'b111, 1'b1, 1'b0, 32'h8000000C};
        vec[5] = '{1'b0, 1'b0, 3'd0, 32'h00000000, 2'd3, 5'd9,  3'b111, 1'b0, 1'b0, 32'h80000018};
        vec[6] = '{1'b0, 1'b1, 3'd0, 32'h00000000, 2'd0, 5'd9,  3'b111, 1'b0, 1'b1, 32'h80000018};
        vec[7] = '{1'b1, 1'b1, 3'd3, 32'h90000000, 2'd3, 5'd0,  3'b000, 1'b0, 1'b1, 32'h00000000};

        doReset("reset0");

        foreach (vec[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            @(negedge clk);
            applyStimulus(vec[k].flush, vec[k].fv, vec[k].cnt, vec[k].pc, vec[k].acc);
            settle();
            check({tag, ".count"}, 96'(count),    96'(vec[k].exp_count));
            check({tag, ".valid"}, 96'(dvalid),   96'(vec[k].exp_valid));
            check({tag, ".buble"}, 96'(buble),    96'(vec[k].exp_buble));
            check({tag, ".err"},   96'(err),      96'(vec[k].exp_err));
            check({tag, ".pc0"},   96'(dpc[31:0]), 96'(vec[k].exp_pc0));
        end

        // With four entries buffered, a five-wide enqueue and a three-wide dequeue in the same cycle give six.
        doReset("reset1");
        runCycle("q4", 1'b0, 1'b1, 3'd4, 32'h00002000, 2'd0);
        runCycle("q4acc", 1'b0, 1'b1, 3'd5, 32'h00003000, 2'd3);
        settle();
        check("simul.count", 96'(count), 96'(6));
        check("simul.pc0",   96'(dpc[31:0]), 96'(32'h0000200C));
        runCycle("simul.after", 1'b0, 1'b0, 3'd0, 32'h0, 2'd0);

        // Advance tail to 14 and drain, then enqueue five entries that wrap past the end of storage.
        doReset("reset2");
        runCycle("w0", 1'b0, 1'b1, 3'd5, 32'h00000100, 2'd0);
        runCycle("w1", 1'b0, 1'b1, 3'd5, 32'h00000114, 2'd0);
        runCycle("w2", 1'b0, 1'b1, 3'd4, 32'h00000128, 2'd0);
        for (int k = 0; k < 5; k++)
            runCycle("wdrain", 1'b0, 1'b0, 3'd0, 32'h0, (mq.size() >= 3) ? 2'd3 : 2'(mq.size()));
        runCycle("wenq", 1'b0, 1'b1, 3'd5, 32'h00001000, 2'd0);
        for (int k = 0; k < 5; k++) begin
            settle();
            check("wrap.pc0", 96'(dpc[31:0]), 96'(32'h00001000 + 32'(4 * k)));
            runCycle("wrap", 1'b0, 1'b0, 3'd0, 32'h0, 2'd1);
        end
        runCycle("wrap.empty", 1'b0, 1'b0, 3'd0, 32'h0, 2'd0);

        // Accepting more than is valid drains what exists and sets the sticky error, which a flush keeps.
        doReset("reset3");
        runCycle("o1", 1'b0, 1'b1, 3'd1, 32'h00004000, 2'd0);
        runCycle("o2", 1'b0, 1'b0, 3'd0, 32'h0, 2'd2);
        settle();
        check("over.count", 96'(count), 96'(0));
        check("over.err",   96'(err), 96'(1));
        runCycle("o3", 1'b1, 1'b0, 3'd0, 32'h0, 2'd0);
        runCycle("o4", 1'b0, 1'b0, 3'd0, 32'h0, 2'd0);
        runCycle("o5", 1'b0, 1'b1, 3'd2, 32'h00005000, 2'd0);
        runCycle("o6", 1'b0, 1'b0, 3'd0, 32'h0, 2'd0);

        // Randomized traffic against the model, with a mid-run reset.
        doReset("reset4");
        for (int k = 0; k < 400; k++) begin
            logic        rf;
            logic        rv;
            logic [2:0]  rn;
            logic [1:0]  ra;
            int          vs;
            if (k == 200) doReset("resetmid");
            vs = (mq.size() < 3) ? mq.size() : 3;
            rf = ($urandom_range(0, 19) == 0);
            rv = ($urandom_range(0, 9) < 7);
            rn = 3'($urandom_range(1, 5));
            ra = 2'($urandom_range(0, 3));
            if (int'(ra) > vs && $urandom_range(0, 15) != 0) ra = 2'(vs);
            runCycle("rand", rf, rv, rn, $urandom & 32'hFFFFFFFC, ra);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
